// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the data-memory responder state encoding.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    OPCODE_ADD   = 2'd0,
    OPCODE_LOAD  = 2'd1,
    OPCODE_SUB   = 2'd2,
    OPCODE_STORE = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM: synchronous write, synchronous registered read, gated by i_en.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, LATENCY wait states,
// registered response held until the requester takes it.
module dmem_responder #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  import cpu_pkg::*;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      LAT_L   = 4'(LATENCY);

  rsp_state_t        r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_reqReady;
  logic              r_rspValid;
  logic              r_rspWrite;
  logic              r_rspErr;
  logic              r_loadOk;
  logic              r_busy;

  logic              w_inRange;
  logic              w_access;
  logic [DATA_W-1:0] w_ramRdata;

  assign w_inRange = ({1'b0, r_addr} < DEPTH_L);
  assign w_access  = (r_state == WAIT) && (r_cnt == 4'd0);

  // The RAM commits/reads only on the edge that enters RESP, so a reset during WAIT drops the store.
  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(IDX_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .i_en   (w_access && w_inRange),
    .i_we   (r_write),
    .i_addr (r_addr[IDX_W-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_ramRdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspWrite <= 1'b0;
      r_rspErr   <= 1'b0;
      r_loadOk   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= LAT_L;
            r_state    <= WAIT;
            r_reqReady <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= RESP;
            r_rspValid <= 1'b1;
            r_rspWrite <= r_write;
            r_rspErr   <= !w_inRange;
            r_loadOk   <= !r_write && w_inRange;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_write = r_rspWrite;
  assign rsp_err   = r_rspErr;
  assign busy      = r_busy;
  // Stores and errors never load the RAM output, so their response data reads as zero.
  assign rsp_rdata = r_loadOk ? w_ramRdata : '0;

endmodule
